// File: rtl/sdm_pkg.sv
// -----------------------------------------------------------------------------
// sdm_pkg
//   Shared definitions for the multi-channel sigma-delta modulator.
//   - iw_of()    : integrator width from sample width and guard bits
//   - fb_pos()   : positive feedback level  ( 2^(BW-1)-1 )
//   - fb_neg()   : negative feedback level  (-2^(BW-1)   )
//   - saturate() : clamps a wide signed value into an IW-bit signed range and
//                  reports whether clamping happened
//   All helpers work on a fixed 64-bit signed carrier; callers slice the
//   result down to their own width.
// -----------------------------------------------------------------------------
package sdm_pkg;

   localparam int unsigned SATW = 64;

   typedef logic signed [SATW-1:0] wide_t;

   typedef struct packed {
      logic  clamp;
      wide_t val;
   } sat_t;

   localparam wide_t WIDE_ONE = 64'sd1;

   function automatic int unsigned iw_of(input int unsigned bw, input int unsigned guard);
      return bw + guard;
   endfunction

   function automatic wide_t fb_pos(input int unsigned bw);
      return (WIDE_ONE <<< (bw - 32'd1)) - WIDE_ONE;
   endfunction

   function automatic wide_t fb_neg(input int unsigned bw);
      return -(WIDE_ONE <<< (bw - 32'd1));
   endfunction

   function automatic sat_t saturate(input wide_t value, input int unsigned iw);
      sat_t  res;
      wide_t hi;
      wide_t lo;
      hi = (WIDE_ONE <<< (iw - 32'd1)) - WIDE_ONE;
      lo = -(WIDE_ONE <<< (iw - 32'd1));
      if (value > hi) begin
         res.clamp = 1'b1;
         res.val   = hi;
      end else if (value < lo) begin
         res.clamp = 1'b1;
         res.val   = lo;
      end else begin
         res.clamp = 1'b0;
         res.val   = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/sdm_multi_chan.sv
// -----------------------------------------------------------------------------
// sdm_chan
//   One sigma-delta channel: integrators r1/r2, saturation and sticky overload.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     en_i           clock enable for integrators and overload set
//     order2_i       loop order from the top-level mode register
//     flush_i        mode change this edge: zero integrators, no overload set
//     ovl_clr_i      clears the overload flag (acts even when en_i=0)
//     sd_i           signed input sample
//     bs_o           output bit (1 when r1 is non-negative)
//     ovl_o          sticky overload flag
// -----------------------------------------------------------------------------
module sdm_chan
   import sdm_pkg::*;
#(
   parameter int unsigned BW = 16,
   parameter int unsigned IW = 18
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 order2_i,
   input  logic                 flush_i,
   input  logic                 ovl_clr_i,
   input  logic signed [BW-1:0] sd_i,
   output logic                 bs_o,
   output logic                 ovl_o
);

   // Sums need IW+3 bits: r1 + r2 + in + 2*fb never exceeds that range.
   localparam int unsigned SW = IW + 3;

   logic signed [IW-1:0] r1_q, r1_d;
   logic signed [IW-1:0] r2_q, r2_d;
   logic                 ovl_q, ovl_d;
   logic signed [SW-1:0] fb_s, in_s, r1_ext_s, r2_ext_s, r1_sum_s, r2_sum_s;
   sat_t                 sat1_s, sat2_s;
   logic                 unused_s;

   // Loop arithmetic, clamping and overload next-state.
   always_comb begin
      fb_s     = r1_q[IW-1] ? SW'(fb_neg(BW)) : SW'(fb_pos(BW));
      in_s     = SW'(sd_i);
      r1_ext_s = SW'(r1_q);
      r2_ext_s = SW'(r2_q);
      if (order2_i) begin
         r1_sum_s = r1_ext_s + r2_ext_s + in_s - fb_s - fb_s;
         r2_sum_s = r2_ext_s + in_s - fb_s;
      end else begin
         r1_sum_s = r1_ext_s + in_s - fb_s;
         r2_sum_s = {SW{1'b0}};
      end
      sat1_s = saturate(SATW'(r1_sum_s), IW);
      sat2_s = saturate(SATW'(r2_sum_s), IW);
      r1_d   = sat1_s.val[IW-1:0];
      r2_d   = sat2_s.val[IW-1:0];
      // A fresh clamp beats a simultaneous clear.
      if (en_i && !flush_i && (sat1_s.clamp || sat2_s.clamp)) begin
         ovl_d = 1'b1;
      end else if (ovl_clr_i) begin
         ovl_d = 1'b0;
      end else begin
         ovl_d = ovl_q;
      end
   end

   // Upper bits of the clamped carrier are a sign extension and carry nothing.
   assign unused_s = ^{sat1_s.val[SATW-1:IW], sat2_s.val[SATW-1:IW]};

   // Integrator and overload state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r1_q  <= {IW{1'b0}};
         r2_q  <= {IW{1'b0}};
         ovl_q <= 1'b0;
      end else begin
         if (en_i) begin
            if (flush_i) begin
               r1_q <= {IW{1'b0}};
               r2_q <= {IW{1'b0}};
            end else begin
               r1_q <= r1_d;
               r2_q <= r2_d;
            end
         end else begin
            r1_q <= r1_q;
            r2_q <= r2_q;
         end
         ovl_q <= ovl_d;
      end
   end

   assign bs_o  = ~r1_q[IW-1];
   assign ovl_o = ovl_q;

endmodule

// File: rtl/sdm_multi.sv
// -----------------------------------------------------------------------------
// sdm_multi
//   NCH-channel sigma-delta modulator with run-time 1st/2nd order selection.
//   Ports:
//     clk       clock
//     rst       synchronous active-high reset
//     en        clock enable
//     order2    1 = 2nd-order loop, 0 = 1st-order loop (all channels)
//     sd_in     channel c sample at [c*BW +: BW], signed
//     ovl_clr   clears all overload flags
//     bs_out    bitstream, one bit per channel
//     ovl       sticky overload flag per channel
// -----------------------------------------------------------------------------
module sdm_multi
   import sdm_pkg::*;
#(
   parameter int unsigned BW    = 16,
   parameter int unsigned NCH   = 2,
   parameter int unsigned GUARD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              order2,
   input  logic [NCH*BW-1:0] sd_in,
   input  logic              ovl_clr,
   output logic [NCH-1:0]    bs_out,
   output logic [NCH-1:0]    ovl
);

   localparam int unsigned IW = iw_of(BW, GUARD);

   logic mode_q, mode_d;
   logic flush_s;

   // An enabled edge that sees a new order restarts every loop from zero.
   always_comb begin
      flush_s = en && (order2 != mode_q);
      if (en) begin
         mode_d = order2;
      end else begin
         mode_d = mode_q;
      end
   end

   // Mode register; reset loads the current order directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= order2;
      end else begin
         mode_q <= mode_d;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      sdm_chan #(
         .BW (BW),
         .IW (IW)
      ) u_chan (
         .clk_i     (clk),
         .rst_i     (rst),
         .en_i      (en),
         .order2_i  (mode_q),
         .flush_i   (flush_s),
         .ovl_clr_i (ovl_clr),
         .sd_i      (sd_in[c*BW +: BW]),
         .bs_o      (bs_out[c]),
         .ovl_o     (ovl[c])
      );
   end

endmodule

// File: tb/tb_sdm_multi.sv
// -----------------------------------------------------------------------------
// tb_sdm_multi
//   Two instances (GUARD=2 and GUARD=0) share the same stimulus. A plain
//   integer model of the modulator equations runs alongside and both outputs
//   of both instances are compared with it on every falling edge.
// -----------------------------------------------------------------------------
module tb_sdm_multi;

   localparam int BW  = 16;
   localparam int NCH = 2;

   logic              clk = 1'b0;
   logic              rst, en, order2, ovl_clr;
   logic [NCH*BW-1:0] sd_in;
   logic [NCH-1:0]    bs_a, ovl_a, bs_b, ovl_b;

   int n_checks = 0;
   int n_errors = 0;

   longint m_r1 [2][NCH];
   longint m_r2 [2][NCH];
   bit     m_ovl[2][NCH];
   bit     m_mode;
   bit     chk_on = 1'b0;

   always #5 clk = ~clk;

   sdm_multi #(.BW(16), .NCH(2), .GUARD(2)) u_dut (
      .clk(clk), .rst(rst), .en(en), .order2(order2), .sd_in(sd_in),
      .ovl_clr(ovl_clr), .bs_out(bs_a), .ovl(ovl_a));

   sdm_multi #(.BW(16), .NCH(2), .GUARD(0)) u_dut_g0 (
      .clk(clk), .rst(rst), .en(en), .order2(order2), .sd_in(sd_in),
      .ovl_clr(ovl_clr), .bs_out(bs_b), .ovl(ovl_b));

   function automatic int guard_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_val(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic logic [1:0] exp_bs(input int d);
      logic [1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (m_r1[d][c] >= 0);
      return r;
   endfunction

   function automatic logic [1:0] exp_ovl(input int d);
      logic [1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = m_ovl[d][c];
      return r;
   endfunction

   // Reference model: integer form of the loop equations.
   always @(posedge clk) begin
      longint x, fb, n1, n2, lim;
      bit     hit;
      if (rst) begin
         chk_on = 1'b1;
         m_mode = order2;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
               m_r1[d][c] = 0; m_r2[d][c] = 0; m_ovl[d][c] = 1'b0;
            end
      end else if (en && (order2 != m_mode)) begin
         m_mode = order2;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
               m_r1[d][c] = 0; m_r2[d][c] = 0;
               if (ovl_clr) m_ovl[d][c] = 1'b0;
            end
      end else begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
               hit = 1'b0;
               if (en) begin
                  x  = longint'($signed(sd_in[c*BW +: BW]));
                  fb = (m_r1[d][c] < 0) ? -(longint'(1) << (BW-1)) : (longint'(1) << (BW-1)) - 1;
                  if (m_mode) begin
                     n1 = m_r1[d][c] + m_r2[d][c] + x - 2*fb;
                     n2 = m_r2[d][c] + x - fb;
                  end else begin
                     n1 = m_r1[d][c] + x - fb;
                     n2 = 0;
                  end
                  lim = longint'(1) << (BW + guard_of(d) - 1);
                  if (n1 > lim-1) begin n1 = lim-1; hit = 1'b1; end
                  if (n1 < -lim)  begin n1 = -lim;  hit = 1'b1; end
                  if (n2 > lim-1) begin n2 = lim-1; hit = 1'b1; end
                  if (n2 < -lim)  begin n2 = -lim;  hit = 1'b1; end
                  m_r1[d][c] = n1;
                  m_r2[d][c] = n2;
               end
               if (hit) m_ovl[d][c] = 1'b1;
               else if (ovl_clr) m_ovl[d][c] = 1'b0;
            end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check2("bs_g2",  bs_a,  exp_bs(0));
         check2("ovl_g2", ovl_a, exp_ovl(0));
         check2("bs_g0",  bs_b,  exp_bs(1));
         check2("ovl_g0", ovl_b, exp_ovl(1));
      end
   end

   task automatic do_reset(input logic ord);
      rst = 1'b1; en = 1'b0; order2 = ord; ovl_clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int ones0, ones1;
      logic [1:0] held_bs, held_ovl;

      // 1. Reset with random input, then first edge from zero state
      rst = 1'b1; en = 1'b0; order2 = 1'b1; ovl_clr = 1'b0; sd_in = $urandom;
      @(negedge clk); sd_in = $urandom; en = 1'b1;
      @(negedge clk);
      check2("reset_bs",  bs_a,  2'b11);
      check2("reset_ovl", ovl_a, 2'b00);
      check2("reset_bs_g0", bs_b, 2'b11);
      rst = 1'b0; en = 1'b1; sd_in = '0;
      @(negedge clk);
      check2("first_edge_bs", bs_a, 2'b00);
      check_val("model_r1_first", m_r1[0][0], -65534);
      check_val("model_r2_first", m_r2[0][0], -32767);

      // 2. DC density, 2nd order
      do_reset(1'b1);
      en = 1'b1; sd_in = {16'h4000, 16'h0000};
      ones0 = 0; ones1 = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         ones0 += int'(bs_a[0]); ones1 += int'(bs_a[1]);
      end
      check_rng("density_o2_ch0", ones0, 510, 514);
      check_rng("density_o2_ch1", ones1, 764, 772);
      check2("density_o2_ovl", ovl_a, 2'b00);

      // 3. DC density, 1st order; r2 must stay zero
      do_reset(1'b0);
      en = 1'b1; sd_in = {16'h0000, 16'hC000};
      ones0 = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         ones0 += int'(bs_a[0]);
         check_val("o1_r2_zero", longint'(u_dut.g_chan[0].u_chan.r2_q), 0);
      end
      check_rng("density_o1_ch0", ones0, 254, 258);
      check2("density_o1_ovl", ovl_a, 2'b00);

      // 4. Overload on the GUARD=0 instance; set beats clear
      do_reset(1'b0);
      en = 1'b1; sd_in = {16'h0000, 16'h8000}; ovl_clr = 1'b1;
      @(negedge clk);
      check2("ovl_set_wins_g0", ovl_b, 2'b01);
      check2("ovl_none_g2",     ovl_a, 2'b00);
      @(negedge clk);
      check2("ovl_clr_g0", ovl_b, 2'b00);
      ovl_clr = 1'b0; sd_in = '0;
      repeat (4) @(negedge clk);

      // 5. Enable hold
      do_reset(1'b1);
      en = 1'b1;
      for (int i = 0; i < 50; i++) begin sd_in = $urandom; @(negedge clk); end
      held_bs = bs_a; held_ovl = ovl_a; en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sd_in = $urandom;
         @(negedge clk);
         check2("hold_bs", bs_a, held_bs);
         check2("hold_ovl", ovl_a, held_ovl);
      end
      en = 1'b1;
      for (int i = 0; i < 50; i++) begin sd_in = $urandom; @(negedge clk); end

      // 6. Mode switch, then reset coinciding with a switch
      do_reset(1'b1);
      en = 1'b1; sd_in = {16'h0000, 16'd8000};
      repeat (100) @(negedge clk);
      held_ovl = ovl_a; order2 = 1'b0;
      @(negedge clk);
      check2("switch_bs", bs_a, 2'b11);
      check2("switch_ovl", ovl_a, held_ovl);
      repeat (5) @(negedge clk);
      rst = 1'b1; order2 = 1'b1;
      @(negedge clk);
      check2("rst_switch_bs", bs_a, 2'b11);
      check2("rst_switch_ovl", ovl_a, 2'b00);
      rst = 1'b0; sd_in = '0;
      @(negedge clk);
      check2("rst_mode_taken_bs", bs_a, 2'b00);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 199) == 0);
         en      = ($urandom_range(0, 9) != 0);
         ovl_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) == 0) order2 = ~order2;
         for (int c = 0; c < NCH; c++) begin
            case ($urandom_range(0, 3))
               0: sd_in[c*BW +: BW] = 16'h8000;
               1: sd_in[c*BW +: BW] = 16'h7FFF;
               default: sd_in[c*BW +: BW] = 16'($urandom);
            endcase
         end
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
